// File: rtl/uart_pkg.sv
// Shared types, default constants and the parity helper for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int         CLK_PER_BIT_115200 = 868;
    localparam logic [7:0] CHAR_EMPTY         = 8'h65;
    localparam logic [7:0] CHAR_FULL          = 8'h66;

    // Expected parity bit for a zero-extended data word: even makes the total count of ones even.
    function automatic logic parity_bit(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_fifo_core.sv
// Synchronous FIFO with occupancy count, full/empty flags and a registered read port.
module uart_fifo_core #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       rd_en_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       wr_drop_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] data_q;
    logic              do_wr;
    logic              do_rd;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign data_o    = data_q;
    assign do_rd     = rd_en_i && !empty_o;
    // A write into a full FIFO survives only when a pop frees the head slot on the same edge.
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign wr_drop_o = wr_en_i && !do_wr;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                data_q   <= mem_q[rd_ptr_q];
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Mid-bit sampling UART receiver with optional parity, sticky error flags and a boot marker,
// feeding a host-readable FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int         CLK_PER_BIT = CLK_PER_BIT_115200,
    parameter int         DATA_W      = 8,
    parameter int         DEPTH       = 16,
    parameter int         PARITY_EN   = 0,
    parameter int         PARITY_ODD  = 0,
    parameter int         BOOT_EN     = 1,
    parameter logic [7:0] BOOT_CHAR   = CHAR_EMPTY
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_serial,
    input  logic                   rd_en_i,
    output logic [DATA_W-1:0]      data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   frame_err_o,
    output logic                   parity_err_o,
    output logic                   overrun_o,
    input  logic                   clr_err_i
);
    localparam int                CNT_W    = $clog2(CLK_PER_BIT);
    localparam int                BIT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] BOOT_W   = DATA_W'(BOOT_CHAR);

    rx_state_e         state_q;
    logic              sync1_q;
    logic              sync2_q;
    logic              prev_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0] shift_q;
    logic              bad_q;
    logic              wr_q;
    logic              boot_q;
    logic              frame_err_q;
    logic              parity_err_q;
    logic              overrun_q;
    logic              fifo_wr_d;
    logic [DATA_W-1:0] fifo_data_d;
    logic              fifo_drop;

    assign fifo_wr_d    = wr_q || boot_q;
    assign fifo_data_d  = boot_q ? BOOT_W : shift_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overrun_o    = overrun_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            bad_q        <= 1'b0;
            wr_q         <= 1'b0;
            boot_q       <= (BOOT_EN != 0);
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            wr_q    <= 1'b0;
            boot_q  <= 1'b0;

            // Clear first so that any set below in the same cycle takes precedence.
            if (clr_err_i) begin
                frame_err_q  <= 1'b0;
                parity_err_q <= 1'b0;
                overrun_q    <= 1'b0;
            end
            if (fifo_drop) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        bad_q <= 1'b0;
                        state_q <= sync2_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[DATA_W-1:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        bad_q   <= (sync2_q != parity_bit(16'(shift_q), (PARITY_ODD != 0)));
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (!sync2_q) begin
                            frame_err_q <= 1'b1;
                        end else if (bad_q) begin
                            parity_err_q <= 1'b1;
                        end else begin
                            wr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    uart_fifo_core #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en_i   (fifo_wr_d),
        .wr_data_i (fifo_data_d),
        .rd_en_i   (rd_en_i),
        .data_o    (data_o),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .count_o   (count_o),
        .wr_drop_o (fifo_drop)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: boot-marker, parity and plain/small-FIFO instances of uart_rx_fifo.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_l  [3];
    logic rd_l  [3];
    logic clr_l [3];

    logic [7:0] b_data, p_data, m_data;
    logic       b_full, b_empty, b_fe, b_pe, b_ov;
    logic       p_full, p_empty, p_fe, p_pe, p_ov;
    logic       m_full, m_empty, m_fe, m_pe, m_ov;
    logic [4:0] b_cnt, p_cnt;
    logic [2:0] m_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_PER_BIT(16), .DATA_W(8), .DEPTH(16), .PARITY_EN(0), .PARITY_ODD(0),
                   .BOOT_EN(1), .BOOT_CHAR(8'h65)) u_boot (
        .clk(clk), .rst(rst), .rx_serial(rx_l[0]), .rd_en_i(rd_l[0]), .data_o(b_data),
        .full_o(b_full), .empty_o(b_empty), .count_o(b_cnt), .frame_err_o(b_fe),
        .parity_err_o(b_pe), .overrun_o(b_ov), .clr_err_i(clr_l[0]));

    uart_rx_fifo #(.CLK_PER_BIT(16), .DATA_W(8), .DEPTH(16), .PARITY_EN(1), .PARITY_ODD(0),
                   .BOOT_EN(0), .BOOT_CHAR(8'h65)) u_par (
        .clk(clk), .rst(rst), .rx_serial(rx_l[1]), .rd_en_i(rd_l[1]), .data_o(p_data),
        .full_o(p_full), .empty_o(p_empty), .count_o(p_cnt), .frame_err_o(p_fe),
        .parity_err_o(p_pe), .overrun_o(p_ov), .clr_err_i(clr_l[1]));

    uart_rx_fifo #(.CLK_PER_BIT(16), .DATA_W(8), .DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0),
                   .BOOT_EN(0), .BOOT_CHAR(8'h65)) u_main (
        .clk(clk), .rst(rst), .rx_serial(rx_l[2]), .rd_en_i(rd_l[2]), .data_o(m_data),
        .full_o(m_full), .empty_o(m_empty), .count_o(m_cnt), .frame_err_o(m_fe),
        .parity_err_o(m_pe), .overrun_o(m_ov), .clr_err_i(clr_l[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame of 16-cycle bits; rd_at_wr raises rd_en_i exactly on the FIFO write edge.
    task automatic send(input int idx, input logic [7:0] b, input bit use_par, input bit par,
                        input bit stop, input bit rd_at_wr);
        rx_l[idx] = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            rx_l[idx] = b[i];
            repeat (16) tick();
        end
        if (use_par) begin
            rx_l[idx] = par;
            repeat (16) tick();
        end
        rx_l[idx] = stop;
        if (rd_at_wr) begin
            repeat (11) tick();
            rd_l[idx] = 1'b1;
            tick();
            rd_l[idx] = 1'b0;
            repeat (4) tick();
        end else begin
            repeat (16) tick();
        end
        rx_l[idx] = 1'b1;
        repeat (4) tick();
    endtask

    task automatic pop(input int idx);
        rd_l[idx] = 1'b1;
        tick();
        rd_l[idx] = 1'b0;
    endtask

    task automatic clear(input int idx);
        clr_l[idx] = 1'b1;
        tick();
        clr_l[idx] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_tests++;
        if (m_cnt !== 3'd0 || m_empty !== 1'b1 || m_full !== 1'b0 || m_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_fifo cnt=%0d empty=%b full=%b data=%h exp 0/1/0/00", m_cnt, m_empty, m_full, m_data);
        end
        n_tests++;
        if ({m_fe, m_pe, m_ov, b_fe, b_pe, b_ov} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 000000", {m_fe, m_pe, m_ov, b_fe, b_pe, b_ov});
        end
        n_tests++;
        if (b_cnt !== 5'd0 || b_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_boot cnt=%0d empty=%b exp 0/1", b_cnt, b_empty);
        end
        rst = 1'b1;
    endtask

    task automatic test_boot();
        tick();
        n_tests++;
        if (b_cnt !== 5'd1 || b_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_count cnt=%0d empty=%b exp 1/0", b_cnt, b_empty);
        end
        n_tests++;
        if (m_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL noboot_count got %0d exp 0", m_cnt);
        end
        pop(0);
        n_tests++;
        if (b_data !== 8'h65 || b_empty !== 1'b1 || b_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL boot_read data=%h empty=%b cnt=%0d exp 65/1/0", b_data, b_empty, b_cnt);
        end
        pop(0);
        n_tests++;
        if (b_data !== 8'h65 || b_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL empty_read_hold data=%h cnt=%0d exp 65/0", b_data, b_cnt);
        end
    endtask

    task automatic test_basic();
        send(2, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (m_cnt !== 3'd1 || {m_fe, m_pe, m_ov} !== 3'b000) begin
            n_fail++;
            $display("FAIL basic_store cnt=%0d flags=%b exp 1/000", m_cnt, {m_fe, m_pe, m_ov});
        end
        pop(2);
        n_tests++;
        if (m_data !== 8'hA5 || m_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_read data=%h empty=%b exp A5/1", m_data, m_empty);
        end
    endtask

    task automatic test_parity();
        send(1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (p_pe !== 1'b1 || p_cnt !== 5'd0 || p_fe !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_bad pe=%b cnt=%0d fe=%b exp 1/0/0", p_pe, p_cnt, p_fe);
        end
        send(1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (p_cnt !== 5'd1) begin
            n_fail++;
            $display("FAIL parity_good_count got %0d exp 1", p_cnt);
        end
        pop(1);
        n_tests++;
        if (p_data !== 8'h03) begin
            n_fail++;
            $display("FAIL parity_good_data got %h exp 03", p_data);
        end
    endtask

    task automatic test_framing();
        send(2, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (m_fe !== 1'b1 || m_cnt !== 3'd0 || m_pe !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err fe=%b cnt=%0d pe=%b exp 1/0/0", m_fe, m_cnt, m_pe);
        end
        rx_l[2] = 1'b0;
        repeat (3) tick();
        rx_l[2] = 1'b1;
        repeat (200) tick();
        n_tests++;
        if (m_cnt !== 3'd0 || m_fe !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch cnt=%0d fe=%b exp 0/1", m_cnt, m_fe);
        end
        clear(2);
        n_tests++;
        if (m_fe !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_clear got %b exp 0", m_fe);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b;
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            send(2, exp_b, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        n_tests++;
        if (m_full !== 1'b1 || m_cnt !== 3'd4 || m_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full full=%b cnt=%0d ov=%b exp 1/4/0", m_full, m_cnt, m_ov);
        end
        send(2, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (m_ov !== 1'b1 || m_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_overrun ov=%b cnt=%0d exp 1/4", m_ov, m_cnt);
        end
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            pop(2);
            n_tests++;
            if (m_data !== exp_b) begin
                n_fail++;
                $display("FAIL ovf_read%0d got %h exp %h", i, m_data, exp_b);
            end
        end
        send(2, 8'h06, 1'b0, 1'b0, 1'b1, 1'b0);
        send(2, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
        pop(2);
        n_tests++;
        if (m_data !== 8'h06) begin
            n_fail++;
            $display("FAIL wrap_read06 got %h exp 06", m_data);
        end
        pop(2);
        n_tests++;
        if (m_data !== 8'h07 || m_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_read07 data=%h empty=%b exp 07/1", m_data, m_empty);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_q [4];
        clear(2);
        n_tests++;
        if (m_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear got %b exp 0", m_ov);
        end
        send(2, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
        send(2, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        send(2, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
        send(2, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0);
        send(2, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if (m_ov !== 1'b0 || m_cnt !== 3'd4 || m_full !== 1'b1) begin
            n_fail++;
            $display("FAIL fullrw_state ov=%b cnt=%0d full=%b exp 0/4/1", m_ov, m_cnt, m_full);
        end
        n_tests++;
        if (m_data !== 8'h10) begin
            n_fail++;
            $display("FAIL fullrw_pop got %h exp 10", m_data);
        end
        exp_q[0] = 8'h11; exp_q[1] = 8'h12; exp_q[2] = 8'h13; exp_q[3] = 8'h99;
        for (int i = 0; i < 4; i++) begin
            pop(2);
            n_tests++;
            if (m_data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL fullrw_read%0d got %h exp %h", i, m_data, exp_q[i]);
            end
        end
        n_tests++;
        if (m_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL fullrw_empty got %b exp 1", m_empty);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx_l[i]  = 1'b1;
            rd_l[i]  = 1'b0;
            clr_l[i] = 1'b0;
        end
        #1;
        test_reset();
        test_boot();
        test_basic();
        test_parity();
        test_framing();
        test_overflow();
        test_full_rw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
